// File: rtl/prog_load_ctrl_pkg.sv
// Shared definitions for the UART program loader: FSM states, error codes
// and the default frame start marker.
package prog_load_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_RUN,
    ST_WAIT_SYNC,
    ST_WAIT_LEN,
    ST_DATA_LO,
    ST_DATA_HI,
    ST_CHECK,
    ST_ERROR
  } state_e;

  localparam logic [1:0] ERR_NONE     = 2'd0;
  localparam logic [1:0] ERR_LEN_ZERO = 2'd1;
  localparam logic [1:0] ERR_CSUM     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

  // States in which a frame is being received and the byte timer runs.
  function automatic logic in_frame(input state_e s);
    return (s == ST_WAIT_LEN) || (s == ST_DATA_LO) ||
           (s == ST_DATA_HI) || (s == ST_CHECK);
  endfunction

endpackage

// File: rtl/prog_load_ctrl_rx_timeout_timer.sv
// Inter-byte watchdog: counts enabled cycles since the last clear and flags
// expiry on the cycle the count would reach TIMEOUT.
module rx_timeout_timer #(
  parameter int TIMEOUT = 50000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [16:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = cnt_q + 17'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = enable && !clear && (cnt_q == 17'(TIMEOUT - 1));

endmodule

// File: rtl/prog_load_ctrl.sv
// Program memory owner: parses framed UART loads into RAM and releases the
// CPU with a restart pulse once the frame checksum matches.
module prog_load_ctrl
  import prog_load_ctrl_pkg::*;
#(
  parameter int         ADDR_W    = 8,
  parameter logic [7:0] SYNC_BYTE = DEFAULT_SYNC_BYTE,
  parameter int         TIMEOUT   = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [15:0]       mem_wdata,
  output logic              mem_we,
  output logic              cpu_hold,
  output logic              cpu_restart,
  output logic              mode,
  output logic [ADDR_W-1:0] prog_len,
  output logic              err,
  output logic [1:0]        err_code
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] len_q, len_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0] prog_len_q, prog_len_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        lo_q, lo_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              hold_q, hold_d;
  logic              restart_q, restart_d;
  logic              mode_q, mode_d;
  logic              err_q, err_d;
  logic [1:0]        err_code_q, err_code_d;
  logic              timer_expired;

  rx_timeout_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (rx_valid || !in_frame(state_q)),
    .enable (in_frame(state_q)),
    .expired(timer_expired)
  );

  always_comb begin
    state_d    = state_q;
    len_d      = len_q;
    wcnt_d     = wcnt_q;
    wr_addr_d  = wr_addr_q;
    prog_len_d = prog_len_q;
    csum_d     = csum_q;
    lo_d       = lo_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    hold_d     = hold_q;
    restart_d  = 1'b0;
    mode_d     = mode_q;
    err_d      = err_q;
    err_code_d = err_code_q;

    case (state_q)
      ST_RUN: begin
        // A byte arriving with load_req is deliberately not parsed.
        if (load_req) begin
          state_d    = ST_WAIT_SYNC;
          hold_d     = 1'b1;
          mode_d     = 1'b0;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
        end
      end
      ST_WAIT_SYNC: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_d = ST_WAIT_LEN;
        end
      end
      ST_WAIT_LEN: begin
        if (rx_valid) begin
          if (rx_data == 8'd0) begin
            state_d    = ST_ERROR;
            err_d      = 1'b1;
            err_code_d = ERR_LEN_ZERO;
          end else begin
            len_d   = ADDR_W'(rx_data);
            wcnt_d  = '0;
            csum_d  = 8'd0;
            state_d = ST_DATA_LO;
          end
        end
      end
      ST_DATA_LO: begin
        if (rx_valid) begin
          lo_d    = rx_data;
          csum_d  = csum_q ^ rx_data;
          state_d = ST_DATA_HI;
        end
      end
      ST_DATA_HI: begin
        if (rx_valid) begin
          csum_d    = csum_q ^ rx_data;
          we_d      = 1'b1;
          wr_addr_d = wcnt_q;
          wdata_d   = {rx_data, lo_q};
          wcnt_d    = wcnt_q + ADDR_W'(1);
          state_d   = (wcnt_q == len_q - ADDR_W'(1)) ? ST_CHECK : ST_DATA_LO;
        end
      end
      ST_CHECK: begin
        if (rx_valid) begin
          if (rx_data == csum_q) begin
            state_d    = ST_RUN;
            prog_len_d = len_q;
            restart_d  = 1'b1;
            mode_d     = 1'b1;
            hold_d     = 1'b0;
          end else begin
            state_d    = ST_ERROR;
            err_d      = 1'b1;
            err_code_d = ERR_CSUM;
          end
        end
      end
      ST_ERROR: begin
        if (load_req) begin
          state_d    = ST_WAIT_SYNC;
          err_d      = 1'b0;
          err_code_d = ERR_NONE;
        end
      end
      default: state_d = ST_WAIT_SYNC;
    endcase

    if (timer_expired) begin
      state_d    = ST_ERROR;
      we_d       = 1'b0;
      err_d      = 1'b1;
      err_code_d = ERR_TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_WAIT_SYNC;
      len_q      <= '0;
      wcnt_q     <= '0;
      wr_addr_q  <= '0;
      prog_len_q <= '0;
      csum_q     <= 8'd0;
      lo_q       <= 8'd0;
      wdata_q    <= 16'd0;
      we_q       <= 1'b0;
      hold_q     <= 1'b1;
      restart_q  <= 1'b0;
      mode_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      wcnt_q     <= wcnt_d;
      wr_addr_q  <= wr_addr_d;
      prog_len_q <= prog_len_d;
      csum_q     <= csum_d;
      lo_q       <= lo_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      hold_q     <= hold_d;
      restart_q  <= restart_d;
      mode_q     <= mode_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // In RUN the CPU PC addresses memory directly; otherwise the loader's last write address.
  assign mem_addr    = (state_q == ST_RUN) ? fetch_addr : wr_addr_q;
  assign mem_wdata   = wdata_q;
  assign mem_we      = we_q;
  assign cpu_hold    = hold_q;
  assign cpu_restart = restart_q;
  assign mode        = mode_q;
  assign prog_len    = prog_len_q;
  assign err         = err_q;
  assign err_code    = err_code_q;

endmodule

// File: tb/tb_prog_load_ctrl.sv
// Self-checking bench for prog_load_ctrl: a per-cycle vector table for a
// full good load plus directed sequences for errors, timeout and reset.
module tb_prog_load_ctrl;

  localparam int ADDR_W  = 8;
  localparam int TIMEOUT = 40;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              load_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_we;
  logic              cpu_hold;
  logic              cpu_restart;
  logic              mode;
  logic [ADDR_W-1:0] prog_len;
  logic              err;
  logic [1:0]        err_code;

  typedef struct packed {
    logic        mode;
    logic        hold;
    logic        restart;
    logic        we;
    logic        err;
    logic [1:0]  code;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic [7:0]  plen;
  } outs_t;

  typedef struct {
    logic       rxv;
    logic [7:0] rx;
    logic [7:0] fetch;
    outs_t      exp;
  } vec_t;

  vec_t        vecs[$];
  logic [15:0] ram [256];
  int          we_count = 0;
  int          restart_count = 0;
  int          tests = 0;
  int          fails = 0;

  prog_load_ctrl #(
    .ADDR_W   (ADDR_W),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT  (TIMEOUT)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .load_req   (load_req),
    .fetch_addr (fetch_addr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .cpu_hold   (cpu_hold),
    .cpu_restart(cpu_restart),
    .mode       (mode),
    .prog_len   (prog_len),
    .err        (err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  // Behavioural program RAM plus pulse counters observed at the clock edge.
  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_addr] <= mem_wdata;
      we_count = we_count + 1;
    end
    if (cpu_restart) begin
      restart_count = restart_count + 1;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic outs_t mk(input logic m, input logic h, input logic r, input logic w,
                               input logic e, input logic [1:0] c, input logic [7:0] a,
                               input logic [15:0] d, input logic [7:0] p);
    outs_t o;
    o = {m, h, r, w, e, c, a, d, p};
    return o;
  endfunction

  function automatic outs_t actual();
    outs_t o;
    o = {mode, cpu_hold, cpu_restart, mem_we, err, err_code, mem_addr, mem_wdata, prog_len};
    return o;
  endfunction

  task automatic addVec(input logic rxv, input logic [7:0] rx, input logic [7:0] fetch,
                        input outs_t e);
    vec_t v;
    v.rxv   = rxv;
    v.rx    = rx;
    v.fetch = fetch;
    v.exp   = e;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input outs_t e);
    outs_t a;
    a = actual();
    tests++;
    if (a !== e) begin
      fails++;
      $display("[TB] FAIL %s: got mode/hold/rst/we/err/code/addr/wdata/plen=%b/%b/%b/%b/%b/%0d/%h/%h/%0d, expected %b/%b/%b/%b/%b/%0d/%h/%h/%0d",
               name, a.mode, a.hold, a.restart, a.we, a.err, a.code, a.addr, a.wdata, a.plen,
               e.mode, e.hold, e.restart, e.we, e.err, e.code, e.addr, e.wdata, e.plen);
    end
  endtask

  task automatic checkVal(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    rx_valid   = v.rxv;
    rx_data    = v.rx;
    fetch_addr = v.fetch;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    load_req = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic pulseLoadReq();
    load_req = 1'b1;
    @(posedge clk);
    #1;
    load_req = 1'b0;
  endtask

  task automatic sendGoodFrame();
    sendByte(8'hA5); sendByte(8'h02); sendByte(8'h34); sendByte(8'h12);
    sendByte(8'h78); sendByte(8'h56); sendByte(8'h08);
  endtask

  initial begin
    int we_snap;
    int rst_snap;
    outs_t idle_load;

    reset      = 1'b1;
    rx_valid   = 1'b0;
    rx_data    = 8'h00;
    load_req   = 1'b0;
    fetch_addr = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Test 1: cycle-accurate good load of mem[0]=1234, mem[1]=5678.
    idle_load = mk(0, 1, 0, 0, 0, 2'd0, 8'h00, 16'h0000, 8'd0);
    checkOutput("reset_state", idle_load);
    addVec(1, 8'hA5, 8'hEE, idle_load);
    addVec(0, 8'h00, 8'hEE, idle_load);
    addVec(1, 8'h02, 8'hEE, idle_load);
    addVec(0, 8'h00, 8'hEE, idle_load);
    addVec(1, 8'h34, 8'hEE, idle_load);
    addVec(0, 8'h00, 8'hEE, idle_load);
    addVec(1, 8'h12, 8'hEE, mk(0, 1, 0, 1, 0, 2'd0, 8'h00, 16'h1234, 8'd0));
    addVec(0, 8'h00, 8'hEE, mk(0, 1, 0, 0, 0, 2'd0, 8'h00, 16'h1234, 8'd0));
    addVec(1, 8'h78, 8'hEE, mk(0, 1, 0, 0, 0, 2'd0, 8'h00, 16'h1234, 8'd0));
    addVec(0, 8'h00, 8'hEE, mk(0, 1, 0, 0, 0, 2'd0, 8'h00, 16'h1234, 8'd0));
    addVec(1, 8'h56, 8'hEE, mk(0, 1, 0, 1, 0, 2'd0, 8'h01, 16'h5678, 8'd0));
    addVec(0, 8'h00, 8'hEE, mk(0, 1, 0, 0, 0, 2'd0, 8'h01, 16'h5678, 8'd0));
    addVec(1, 8'h08, 8'h3C, mk(1, 0, 1, 0, 0, 2'd0, 8'h3C, 16'h5678, 8'd2));
    addVec(0, 8'h00, 8'h3C, mk(1, 0, 0, 0, 0, 2'd0, 8'h3C, 16'h5678, 8'd2));
    addVec(0, 8'h00, 8'h07, mk(1, 0, 0, 0, 0, 2'd0, 8'h07, 16'h5678, 8'd2));
    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("t1_vec%0d", i), vecs[i].exp);
    end
    rx_valid = 1'b0;
    checkVal("t1_ram0", 32'(ram[0]), 32'h1234);
    checkVal("t1_ram1", 32'(ram[1]), 32'h5678);
    checkVal("t1_we_count", 32'(we_count), 32'd2);
    checkVal("t1_restart_count", 32'(restart_count), 32'd1);

    // Test 2: bad checksum, recovery via load_req and a good frame.
    doReset();
    sendByte(8'hA5); sendByte(8'h02); sendByte(8'h34); sendByte(8'h12);
    sendByte(8'h78); sendByte(8'h56); sendByte(8'h09);
    checkVal("t2_err_csum", {28'd0, err, err_code, cpu_hold}, {28'd0, 1'b1, 2'd2, 1'b1});
    checkVal("t2_mode_after_bad", 32'(mode), 32'd0);
    pulseLoadReq();
    checkVal("t2_err_cleared", {29'd0, err, err_code}, 32'd0);
    rst_snap = restart_count;
    sendGoodFrame();
    checkVal("t2_run", {28'd0, mode, cpu_hold, err, 1'b0}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b0});
    checkVal("t2_prog_len", 32'(prog_len), 32'd2);
    checkVal("t2_restart_pulses", 32'(restart_count - rst_snap), 32'd1);

    // Test 3: leading junk ignored, zero length rejected without writes.
    doReset();
    we_snap = we_count;
    sendByte(8'h00); sendByte(8'hFF);
    checkVal("t3_junk_no_err", 32'(err), 32'd0);
    sendByte(8'hA5); sendByte(8'h00);
    checkVal("t3_len_zero", {29'd0, err, err_code}, {29'd0, 1'b1, 2'd1});
    checkVal("t3_no_we", 32'(we_count - we_snap), 32'd0);

    // Test 4: stall after the first data byte trips the byte timeout exactly at TIMEOUT.
    doReset();
    we_snap = we_count;
    sendByte(8'hA5); sendByte(8'h02);
    rx_valid = 1'b1;
    rx_data  = 8'h34;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
    repeat (TIMEOUT - 1) @(posedge clk);
    #1;
    checkVal("t4_before_timeout", 32'(err), 32'd0);
    @(posedge clk);
    #1;
    checkVal("t4_timeout", {28'd0, err, err_code, cpu_hold}, {28'd0, 1'b1, 2'd3, 1'b1});
    checkVal("t4_no_we", 32'(we_count - we_snap), 32'd0);

    // Test 5: load_req in RUN with a simultaneous byte drops the byte.
    pulseLoadReq();
    sendGoodFrame();
    fetch_addr = 8'h55;
    #1;
    checkVal("t5_fetch_drives_addr", 32'(mem_addr), 32'h55);
    load_req = 1'b1;
    rx_valid = 1'b1;
    rx_data  = 8'hA5;
    @(posedge clk);
    #1;
    load_req = 1'b0;
    rx_valid = 1'b0;
    checkVal("t5_hold_mode", {30'd0, cpu_hold, mode}, {30'd0, 1'b1, 1'b0});
    checkVal("t5_addr_loader", 32'(mem_addr), 32'h01);
    sendByte(8'h00);
    checkVal("t5_byte_dropped", {29'd0, err, err_code}, 32'd0);

    // Test 6: reset mid-frame discards it; a fresh one-word frame loads.
    sendByte(8'hA5); sendByte(8'h03); sendByte(8'h11); sendByte(8'h22);
    doReset();
    checkOutput("t6_after_reset", mk(0, 1, 0, 0, 0, 2'd0, 8'h00, 16'h0000, 8'd0));
    rst_snap = restart_count;
    sendByte(8'hA5); sendByte(8'h01); sendByte(8'hCD); sendByte(8'hAB); sendByte(8'h66);
    checkVal("t6_ram0", 32'(ram[0]), 32'hABCD);
    checkVal("t6_run", {29'd0, mode, cpu_hold, err}, {29'd0, 1'b1, 1'b0, 1'b0});
    checkVal("t6_prog_len", 32'(prog_len), 32'd1);
    checkVal("t6_restart_pulses", 32'(restart_count - rst_snap), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
